// File: rtl/image_compress_ctrl.sv
// Frame controller: buffers one IMG_W x IMG_H frame, runs the compression core over it, queues its bytes.
// Registered outputs, 1-cycle RAM read; pixels stall outside LOAD, core bytes are dropped when the FIFO is full.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             pop_dat_o,
  output logic                     vld_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   cnt_nxt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok, push_ok;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok    = pop_i && (cnt_q != '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign push_ok   = push_i && (!full_o || pop_ok);
  assign cnt_d     = cnt_q + CW'(push_ok) - CW'(pop_ok);
  assign cnt_nxt_o = cnt_d;
  assign vld_o     = (cnt_q != '0);
  assign pop_dat_o = vld_o ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_dat_i;
  end
endmodule

module image_compress_ctrl #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 12,
  parameter int OUT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  s_pix_data,
  input  logic              s_pix_valid,
  output logic              s_pix_ready,
  input  logic              s_pix_last,
  output logic              core_ap_start,
  input  logic              core_ap_ready,
  input  logic              core_ap_done,
  input  logic              core_ap_idle,
  input  logic              core_mem_ce,
  input  logic [ADDR_W-1:0] core_mem_addr,
  output logic [PIX_W-1:0]  core_mem_q,
  output logic [31:0]       core_width,
  output logic [31:0]       core_height,
  input  logic [7:0]        core_byte,
  input  logic              core_byte_vld,
  input  logic [31:0]       core_size,
  input  logic              core_size_vld,
  output logic [7:0]        m_byte_data,
  output logic              m_byte_valid,
  input  logic              m_byte_ready,
  output logic [31:0]       frame_size,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);
  localparam logic [ADDR_W:0] N_EXT    = (ADDR_W + 1)'(N);

  typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rdy_q, start_q, busy_q, done_q;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic          size_seen_q, size_seen_d;
  logic [31:0]   frame_size_q, frame_size_d;
  logic [PIX_W-1:0] rd_dat_q;
  logic [PIX_W-1:0] mem [N];

  logic          pix_acc, byte_push, byte_pop, fifo_full, fifo_vld;
  logic [CW-1:0] fifo_cnt_nxt;
  logic          unused_idle;

  // The start handshake completes on ap_ready, so ap_idle carries no extra information here.
  assign unused_idle = core_ap_idle;

  assign pix_acc   = (state_q == S_LOAD) && rdy_q && s_pix_valid;
  assign byte_push = (state_q == S_RUN) && core_byte_vld;
  assign byte_pop  = fifo_vld && m_byte_ready;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    size_seen_d  = size_seen_q;
    frame_size_d = frame_size_q;
    case (state_q)
      S_LOAD: begin
        if (pix_acc) begin
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = S_START;
            wr_cnt_d = '0;
            if (!s_pix_last) err_d = 1'b1;
          end else if (s_pix_last) begin
            // Short frame: the tail of the buffer keeps the previous frame's pixels.
            state_d  = S_START;
            wr_cnt_d = '0;
            err_d    = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        size_seen_d = 1'b0;
        if (core_ap_ready) state_d = S_RUN;
      end
      S_RUN: begin
        if (core_size_vld) begin
          frame_size_d = core_size;
          size_seen_d  = 1'b1;
        end
        if (byte_push && fifo_full && !byte_pop) ovf_d = 1'b1;
        if (core_ap_done) begin
          state_d = S_DRAIN;
          if (!size_seen_q && !core_size_vld) err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!fifo_vld) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LOAD;
      wr_cnt_q     <= '0;
      rdy_q        <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      size_seen_q  <= 1'b0;
      frame_size_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      size_seen_q  <= size_seen_d;
      frame_size_q <= frame_size_d;
      rdy_q        <= (state_d == S_LOAD);
      start_q      <= (state_d == S_START);
      busy_q       <= (state_d != S_LOAD);
      // Pulse in the DRAIN cycle whose FIFO is empty, which is also the last DRAIN cycle.
      done_q       <= (state_d == S_DRAIN) && (fifo_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (pix_acc) mem[wr_cnt_q] <= s_pix_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_dat_q <= '0;
    end else if (core_mem_ce) begin
      rd_dat_q <= ({1'b0, core_mem_addr} < N_EXT) ? mem[core_mem_addr[AW-1:0]] : '0;
    end
  end

  sync_fifo #(.W(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (byte_push),
    .push_dat_i (core_byte),
    .pop_i      (m_byte_ready),
    .pop_dat_o  (m_byte_data),
    .vld_o      (fifo_vld),
    .full_o     (fifo_full),
    .cnt_nxt_o  (fifo_cnt_nxt)
  );

  assign s_pix_ready   = rdy_q;
  assign core_ap_start = start_q;
  assign core_mem_q    = rd_dat_q;
  assign core_width    = 32'(IMG_W);
  assign core_height   = 32'(IMG_H);
  assign m_byte_valid  = fifo_vld;
  assign frame_size    = frame_size_q;
  assign frame_done    = done_q;
  assign busy          = busy_q;
  assign overflow      = ovf_q;
  assign frame_err     = err_q;
endmodule

// File: doc/image_compress_ctrl.md
# image_compress_ctrl

Parametrised frame controller for the image compression core. It accepts one image as a pixel stream and stores it in an internal IMG_W×IMG_H buffer RAM. It then starts the compression core with ap_ctrl_hs handshaking and serves the core's random-access reads. The core's compressed byte output goes into an output FIFO with valid/ready, and the block reports the frame's compressed size. It sits between the pixel source and `compress_deflate_image`, and replaces fixed-size top-level wiring with a reusable, size-generic front end.

## Interface
- IMG_W, 64, image width in pixels; also driven on `core_width`
- IMG_H, 64, image height in pixels; also driven on `core_height`
- PIX_W, 8, pixel width
- ADDR_W, 12, core address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- OUT_DEPTH, 16, output FIFO depth; power of two, ≥ 2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_pix_data  in  PIX_W  input pixel, raster order
- s_pix_valid  in  1  pixel valid
- s_pix_ready  out  1  pixel accepted when valid && ready
- s_pix_last  in  1  marks the final pixel of the frame
- core_ap_start  out  1  core start
- core_ap_ready / core_ap_done / core_ap_idle  in  1  core control
- core_mem_ce  in  1  core read enable
- core_mem_addr  in  ADDR_W  core read address
- core_mem_q  out  PIX_W  read data
- core_width, core_height  out  32  constants IMG_W, IMG_H
- core_byte  in  8  compressed byte
- core_byte_vld  in  1  byte strobe; the core has no backpressure
- core_size  in  32  compressed size
- core_size_vld  in  1  size strobe
- m_byte_data  out  8  FIFO head
- m_byte_valid  out  1  FIFO non-empty
- m_byte_ready  in  1  pop on valid && ready
- frame_size  out  32  latched compressed size of the last frame
- frame_done  out  1  one-cycle pulse at frame completion
- busy  out  1  high in START/RUN/DRAIN
- overflow  out  1  sticky: byte dropped on full FIFO
- frame_err  out  1  sticky: length/`last` mismatch, or done without a size

## Operation
- N = IMG_W·IMG_H. FSM states: LOAD → START → RUN → DRAIN → LOAD.
- **LOAD**
  - `s_pix_ready` = 1.
  - Each accepted pixel is written to RAM[wr_cnt], then wr_cnt increments.
  - At the N-th accepted pixel: go to START and clear wr_cnt. If `s_pix_last` = 0 on that pixel, set frame_err.
  - If `s_pix_last` = 1 with wr_cnt < N-1: set frame_err and go to START. Unwritten locations keep their previous contents.
- **START**
  - `core_ap_start` = 1, held until `core_ap_ready` is sampled high, then go to RUN.
- **RUN**
  - `core_ap_start` = 0.
  - Every `core_byte_vld` pushes `core_byte` into the FIFO. If the FIFO is full and there is no pop that cycle, the byte is dropped and overflow is set.
  - `core_size_vld` latches `core_size` into frame_size.
  - `core_ap_done` moves the FSM to DRAIN. If no `core_size_vld` was seen in this RUN (including the done cycle), set frame_err and keep the old frame_size.
- **DRAIN**
  - Wait for the FIFO to empty; in that cycle pulse `frame_done`, then go to LOAD.
- **RAM**
  - Depth N, inferred as simple dual-port.
  - Read: `core_mem_q` is registered and updates only when `core_mem_ce` = 1. Addresses ≥ N return 0.
  - Reads are served in every state; reads during LOAD return stale data, no protection.
- **FIFO**
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Count arithmetic is $clog2(OUT_DEPTH)+1 bits; pointers wrap modulo OUT_DEPTH.
- overflow and frame_err clear only on reset.

## Timing
- Reset values: state LOAD; `s_pix_ready` 0 while rst = 0 and 1 from the first clock after release.
  - All other outputs 0: `core_ap_start`, `core_mem_q`, `m_byte_valid`, `m_byte_data`, frame_size, `frame_done`, busy, overflow, frame_err.
  - FIFO empty, counters 0. RAM contents are not cleared.
- Last pixel accepted at edge t: `core_ap_start` = 1 from t+1.
- `core_ap_ready` high at edge t: `core_ap_start` = 0 from t+1.
- `core_mem_ce` at edge t: `core_mem_q` valid after t (1-cycle latency).
- Byte pushed at edge t into an empty FIFO: `m_byte_valid` = 1 after t.
- FIFO goes empty at edge t in DRAIN: `frame_done` is high for cycle t+1.
  - If already empty on entering DRAIN, `frame_done` is high on the first DRAIN cycle.
- Reset mid-frame returns to LOAD and flushes the FIFO.

## Test plan
- IMG 4×4: 16 pixels 0..15 with last on the 16th → one `core_ap_start` pulse. Core-model reads of addr 5 return 5 on the next cycle; addr 20 returns 0.
- Core model emits 10 bytes, `core_size` = 10, then done, with `m_byte_ready` = 1 → 10 bytes in order, frame_size = 10, `frame_done` pulses once, frame_err = 0.
- OUT_DEPTH 4, `m_byte_ready` = 0, core emits 6 bytes → FIFO holds bytes 0..3, overflow = 1, `frame_done` only after 4 pops.
- `s_pix_last` on the 10th of 16 pixels → frame_err = 1 and the core is started. Missing last on the 16th → frame_err = 1.
- `core_ap_ready` delayed 5 cycles → `core_ap_start` held for exactly 6 cycles. Done without `core_size_vld` → frame_err = 1, frame_size unchanged.
- Reset asserted in RUN with 3 bytes queued → `m_byte_valid` = 0 and `s_pix_ready` = 1 after release. A new frame then completes normally.
